// File: rtl/dff_seq_pkg.sv
// dff_seq_pkg: shared types and constants for the flip-flop sequence driver.
package dff_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam int TABLE_DEPTH = 8;
  localparam int ADDR_W = 3;
  localparam int ENTRY_W = 8;
  localparam int HOLD_W = 4;
  localparam int ERR_W = 4;
  localparam int D_BIT = 7;
  localparam int SET_BIT = 6;
  localparam int RST_BIT = 5;
  localparam int EXP_BIT = 4;
  localparam logic [ENTRY_W-1:0] IDLE_ENTRY = 8'b0110_0000;
endpackage

// File: rtl/dff_seq_table.sv
// dff_seq_table: 8x8 stimulus register file, one write port, one combinational read port.
module dff_seq_table
  import dff_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);
  logic [ENTRY_W-1:0] mem [TABLE_DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < TABLE_DEPTH; i++) mem[i] <= IDLE_ENTRY;
    else if (wr_en)
      mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/dff_seq_driver.sv
// dff_seq_driver: plays a table of d/set/reset steps into a flip-flop and checks q/qbar after each.
module dff_seq_driver
  import dff_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              start,
  input  logic              dut_q,
  input  logic              dut_qbar,
  output logic              dut_d,
  output logic              dut_set,
  output logic              dut_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_idx
);
  state_t state;
  logic [ADDR_W-1:0] idx, last, rd_addr;
  logic [HOLD_W-1:0] cnt;
  logic [7:4] cur;
  logic [ENTRY_W-1:0] rd_data, nxt;
  logic wr, mis;
  logic [ERR_W-1:0] err_next;
  assign wr = (state == IDLE) && wr_en;
  assign rd_addr = (state == CHECK) ? idx + 3'd1 : '0;
  // A write in the same idle cycle as start must reach the first driven entry.
  assign nxt = (wr && wr_addr == rd_addr) ? wr_data : rd_data;
  assign mis = (dut_q != cur[EXP_BIT]) || (dut_qbar == dut_q);
  assign err_next = (mis && err_count != '1) ? err_count + 1'b1 : err_count;
  assign dut_d = cur[D_BIT];
  assign dut_set = cur[SET_BIT];
  assign dut_reset = cur[RST_BIT];
  dff_seq_table u_table (
    .clk(clk), .reset(reset), .wr_en(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      cnt <= '0;
      cur <= IDLE_ENTRY[7:4];
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_idx <= '0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            last <= len_m1;
            idx <= '0;
            err_count <= '0;
            first_err_idx <= '0;
            pass <= 1'b0;
            cur <= nxt[7:4];
            cnt <= nxt[HOLD_W-1:0];
            busy <= 1'b1;
            state <= DRIVE;
          end
        end
        DRIVE:
          if (cnt == '0) state <= CHECK;
          else cnt <= cnt - 1'b1;
        CHECK: begin
          err_count <= err_next;
          if (mis && err_count == '0) first_err_idx <= idx;
          if (idx == last) begin
            cur <= IDLE_ENTRY[7:4];
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
            cur <= nxt[7:4];
            cnt <= nxt[HOLD_W-1:0];
            state <= DRIVE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
